// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: PC owner, single-outstanding imem
// req/ack master and a small {pc,instr} buffer toward decode.
package simple_processor_pkg;
  parameter int ADDR_WIDTH = 16;
  parameter int DATA_WIDTH = 32;
endpackage

module instr_fetch_unit
  import simple_processor_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = DATA_WIDTH,
  parameter int PC_INC         = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                      imem_ack_i,
  input  logic                      redirect_i,
  input  logic [MEM_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                      instr_valid_o,
  output logic [MEM_DATA_WIDTH-1:0] instr_o,
  output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                      instr_ready_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C =
    CNT_W'(FIFO_DEPTH);
  localparam logic [MEM_ADDR_WIDTH-1:0] INC_C =
    MEM_ADDR_WIDTH'(PC_INC);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT,
    DRAIN
  } state_e;

  state_e                    state_q;
  logic [MEM_ADDR_WIDTH-1:0] pc_q;
  logic [MEM_ADDR_WIDTH-1:0] drain_addr_q;

  logic [MEM_ADDR_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [MEM_DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wptr_q;
  logic [PTR_W-1:0]          rptr_q;
  logic [CNT_W-1:0]          count_q;

  logic             full;
  logic             req;
  logic             taken;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_d;

  assign full  = (count_q == DEPTH_C);
  assign req   = ((state_q == FETCH) && !full)
              || (state_q == WAIT)
              || (state_q == DRAIN);
  assign taken = req && imem_ack_i;

  // Redirect kills both the returning word and any head pop.
  assign push  = taken && (state_q != DRAIN)
              && !redirect_i && !full;
  assign pop   = (count_q != '0) && instr_ready_i
              && !redirect_i;

  assign count_d = count_q + CNT_W'(push)
                 - CNT_W'(pop);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= BOOT;
      pc_q         <= '0;
      drain_addr_q <= '0;
    end else begin
      unique case (state_q)
        BOOT: begin
          pc_q    <= redirect_i ? redirect_addr_i
                                : boot_addr_i;
          state_q <= FETCH;
        end
        FETCH, WAIT: begin
          if (redirect_i) begin
            pc_q <= redirect_addr_i;
            if (req && !imem_ack_i) begin
              drain_addr_q <= pc_q;
              state_q      <= DRAIN;
            end else begin
              state_q <= FETCH;
            end
          end else if (taken) begin
            pc_q    <= pc_q + INC_C;
            state_q <= (count_d < DEPTH_C) ? WAIT
                                           : FETCH;
          end else begin
            state_q <= req ? WAIT : FETCH;
          end
        end
        DRAIN: begin
          if (redirect_i) pc_q <= redirect_addr_i;
          if (imem_ack_i) state_q <= FETCH;
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (redirect_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_mem_q[wptr_q]   <= pc_q;
        data_mem_q[wptr_q] <= imem_rdata_i;
        wptr_q             <= wptr_q + PTR_W'(1);
      end
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // While draining, the bus keeps the abandoned address.
  assign imem_req_o  = req;
  assign imem_addr_o = (state_q == DRAIN) ? drain_addr_q
                                          : pc_q;

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = data_mem_q[rptr_q];
  assign instr_pc_o    = pc_mem_q[rptr_q];

endmodule
